ex_mem: RTL
===========

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have parameter PERF_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have ports stall  in  6 (pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled) and flush  in  1 (pipeline flush).
REQ-005 SHALL have inputs ex_valid 1, ex_wd 5, ex_wreg 1, ex_wdata 32, ex_hi 32, ex_lo 32, ex_whilo 1 and ex_aluop 8, carrying the EX stage result.
REQ-006 SHALL have inputs hilo_temp_i 64 and cnt_i 2, carrying the EX multicycle (MADD/MSUB) partial product and step count.
REQ-007 SHALL have outputs mem_valid 1, mem_wd 5, mem_wreg 1, mem_wdata 32, mem_hi 32, mem_lo 32, mem_whilo 1 and mem_aluop 8, all registered and feeding MEM and the EX HI/LO forwarding path.
REQ-008 SHALL have outputs hilo_temp_o 64 and cnt_o 2, registered and returned to EX.

Function
REQ-009 SHALL select one mode per cycle, priority top-down: FLUSH (flush=1), HOLD (stall[4]=1), BUBBLE (stall[3]=1, stall[4]=0), RUN (stall[3]=0, stall[4]=0).
REQ-010 FLUSH SHALL clear all mem_* outputs, hilo_temp_o and cnt_o on the next edge, regardless of stall.
REQ-011 RUN SHALL capture every ex_* input into the matching mem_* output with exactly 1-cycle latency (mem_valid<=ex_valid), and SHALL clear hilo_temp_o and cnt_o.
REQ-012 BUBBLE SHALL clear all mem_* outputs (mem_valid=0, mem_wreg=0, mem_whilo=0), and SHALL capture hilo_temp_i into hilo_temp_o and cnt_i into cnt_o.
REQ-013 HOLD SHALL keep every output register unchanged; stall[3]=0 with stall[4]=1 SHALL also resolve to HOLD, so the EX result is not captured.
REQ-014 SHALL gate mem_wreg and mem_whilo to 0 whenever the captured ex_valid is 0.
REQ-015 SHALL pass cnt values through unchanged; the legal sequence 0->1->0 across a BUBBLE then RUN SHALL NOT be altered or re-encoded.
REQ-016 SHALL have no combinational path from any input to any output.

Reset
REQ-017 Asserting rst SHALL immediately force every output to zero (mem_valid=0, cnt_o=0, hilo_temp_o=0, perf counter 0), independent of clk.
REQ-018 On rst deassertion mid-operation, the first edge SHALL follow REQ-009 with no partial-state recovery.

Configuration
REQ-019 Macro EX_MEM_PERF_EN, when defined, SHALL add output perf_retired (PERF_W bits), incremented on each RUN-mode edge capturing ex_valid=1, wrapping from all-ones to 0, cleared only by rst (not flush).
REQ-020 Without EX_MEM_PERF_EN, the perf_retired port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 Bus widths (RegBus 32, RegAddrBus 5, AluOpBus 8, DoubleRegBus 64), stall bit indices and Enable/Disable constants SHALL come from the shared defines package.
REQ-022 SHALL be a single module with no sub-modules; the mode decode SHALL be a local combinational function or signal.

Verification
REQ-023 rst=1 mid-cycle with mem_wdata=0x1234 -> all outputs 0 immediately, before the next clk edge.
REQ-024 RUN, ex_valid=1, ex_wd=5, ex_wreg=1, ex_wdata=0xDEADBEEF -> next edge gives mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF, mem_valid=1; perf_retired increments by 1 if EX_MEM_PERF_EN is defined.
REQ-025 stall=6'b001111, hilo_temp_i=0x0000_0001_FFFF_FFFF, cnt_i=1 -> mem_valid=0, mem_wreg=0, hilo_temp_o=0x0000_0001_FFFF_FFFF, cnt_o=1; then stall=0 -> cnt_o=0 and the EX result is captured.
REQ-026 stall=6'b011111 for 3 cycles with mem_hi=0xA5A5A5A5 held -> all outputs unchanged for 3 cycles.
REQ-027 flush=1 together with stall=6'b011111 -> next edge all outputs 0, cnt_o=0, perf_retired unchanged.
REQ-028 EX_MEM_PERF_EN defined, perf_retired preloaded to 0xFFFFFFFF by running 2^32-1 retirements (or forced), plus one RUN retire -> perf_retired=0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared widths, stall bit indices, enable constants and the mode encoding
// used by the EX/MEM pipeline register and its interface.
package ex_mem_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 8;
    localparam int DREG_BUS_W = 64;
    localparam int CNT_W      = 2;
    localparam int STALL_W    = 6;

    localparam int STALL_EX   = 3;
    localparam int STALL_MEM  = 4;

    localparam logic ENABLE   = 1'b1;
    localparam logic DISABLE  = 1'b0;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_BUBBLE = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_FLUSH  = 2'd3
    } mode_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [REG_BUS_W-1:0]  wdata;
        logic [REG_BUS_W-1:0]  hi;
        logic [REG_BUS_W-1:0]  lo;
        logic                  whilo;
        logic [ALU_OP_W-1:0]   aluop;
    } stage_t;

endpackage

// File: rtl/ex_mem_if.sv
// EX -> MEM result bus plus the multicycle MADD/MSUB loop back to EX.
// The master drives the EX side; the slave (pipeline register) drives the MEM side.
interface ex_mem_if;
    import ex_mem_pkg::*;

    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_wd;
    logic                  ex_wreg;
    logic [REG_BUS_W-1:0]  ex_wdata;
    logic [REG_BUS_W-1:0]  ex_hi;
    logic [REG_BUS_W-1:0]  ex_lo;
    logic                  ex_whilo;
    logic [ALU_OP_W-1:0]   ex_aluop;
    logic [DREG_BUS_W-1:0] hilo_temp_i;
    logic [CNT_W-1:0]      cnt_i;

    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_wd;
    logic                  mem_wreg;
    logic [REG_BUS_W-1:0]  mem_wdata;
    logic [REG_BUS_W-1:0]  mem_hi;
    logic [REG_BUS_W-1:0]  mem_lo;
    logic                  mem_whilo;
    logic [ALU_OP_W-1:0]   mem_aluop;
    logic [DREG_BUS_W-1:0] hilo_temp_o;
    logic [CNT_W-1:0]      cnt_o;

    modport master (
        output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
        output hilo_temp_i, cnt_i,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
        input  hilo_temp_o, cnt_o
    );

    modport slave (
        input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
        input  hilo_temp_i, cnt_i,
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
        output hilo_temp_o, cnt_o
    );

endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: 1-cycle latency, all outputs registered; flush > hold > bubble > run.
// Optional retired-instruction counter perf_retired is built only when EX_MEM_PERF_EN is defined.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    ex_mem_if.slave            bus
`ifdef EX_MEM_PERF_EN
    ,
    output logic [PERF_W-1:0]  perf_retired
`endif
);

    stage_t                stage_q, stage_d;
    logic [DREG_BUS_W-1:0] hilo_q,  hilo_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    mode_e                 mode;

    function automatic mode_e decode_mode(input logic fl, input logic st_mem, input logic st_ex);
        if (fl)          return MODE_FLUSH;
        else if (st_mem) return MODE_HOLD;
        else if (st_ex)  return MODE_BUBBLE;
        return MODE_RUN;
    endfunction

    assign mode = decode_mode(flush, stall[STALL_MEM], stall[STALL_EX]);

    // Only the EX and MEM stall bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_W-1], stall[STALL_EX-1:0]};

    always_comb begin
        stage_d = stage_q;
        hilo_d  = hilo_q;
        cnt_d   = cnt_q;
        unique case (mode)
            MODE_FLUSH: begin
                stage_d = '0;
                hilo_d  = '0;
                cnt_d   = '0;
            end
            MODE_HOLD: begin
            end
            MODE_BUBBLE: begin
                // EX is re-executing a multicycle op: MEM sees a bubble, the partial result loops back.
                stage_d = '0;
                hilo_d  = bus.hilo_temp_i;
                cnt_d   = bus.cnt_i;
            end
            MODE_RUN: begin
                stage_d.valid = bus.ex_valid;
                stage_d.wd    = bus.ex_wd;
                stage_d.wreg  = (bus.ex_valid == ENABLE) ? bus.ex_wreg  : DISABLE;
                stage_d.wdata = bus.ex_wdata;
                stage_d.hi    = bus.ex_hi;
                stage_d.lo    = bus.ex_lo;
                stage_d.whilo = (bus.ex_valid == ENABLE) ? bus.ex_whilo : DISABLE;
                stage_d.aluop = bus.ex_aluop;
                hilo_d        = '0;
                cnt_d         = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            hilo_q  <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            hilo_q  <= hilo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_valid   = stage_q.valid;
    assign bus.mem_wd      = stage_q.wd;
    assign bus.mem_wreg    = stage_q.wreg;
    assign bus.mem_wdata   = stage_q.wdata;
    assign bus.mem_hi      = stage_q.hi;
    assign bus.mem_lo      = stage_q.lo;
    assign bus.mem_whilo   = stage_q.whilo;
    assign bus.mem_aluop   = stage_q.aluop;
    assign bus.hilo_temp_o = hilo_q;
    assign bus.cnt_o       = cnt_q;

`ifdef EX_MEM_PERF_EN
    // Counts retirements into MEM; flush does not clear it, only reset does.
    logic [PERF_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (mode == MODE_RUN && bus.ex_valid == ENABLE) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_retired = perf_q;
`else
    logic unused_perf_w;
    assign unused_perf_w = (PERF_W > 0);
`endif

endmodule
